// File: rtl/operand_normalizer_pkg.sv
// Shared defaults and FSM encoding for the operand normaliser.
// Code 2'b11 is unused and is treated as IDLE by the controller.
package operand_normalizer_pkg;

   localparam int W_DEF  = 16;
   localparam int M_DEF  = 8;
   localparam int CW_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_HOLD  = 2'b10
   } state_t;

endpackage

// File: rtl/operand_normalizer_leading_one_shifter.sv
// One operand lane: loads a value, then left-shifts it once per enabled
// cycle until its MSB is set or W-M shifts have been made.
module leading_one_shifter
   import operand_normalizer_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int M  = M_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          en,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  val,
   output logic [CW-1:0] cnt,
   output logic          need
);

   localparam logic [CW-1:0] MAX_SH = CW'(W - M);

   logic [W-1:0]  opr_q, opr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign need = !opr_q[W-1] && (cnt_q < MAX_SH);
   assign val  = opr_q;
   assign cnt  = cnt_q;

   always_comb begin
      opr_d = opr_q;
      cnt_d = cnt_q;
      if (load) begin
         opr_d = din;
         cnt_d = '0;
      end else if (en && need) begin
         opr_d = opr_q << 1;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opr_q <= '0;
         cnt_q <= '0;
      end else begin
         opr_q <= opr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/operand_normalizer.sv
// Operand normaliser: two leading-one shifter lanes, an IDLE/SHIFT/HOLD
// controller with valid/ready handshakes, and the result shift amount.
module operand_normalizer
   import operand_normalizer_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int M  = M_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          shifting_a,
   output logic          shifting_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [M-1:0]  man_a,
   output logic [M-1:0]  man_b,
   output logic [CW:0]   shamt,
   output logic          zero
);

   localparam logic [CW:0] TOTAL_SH = (CW + 1)'(2 * (W - M));

   state_t        state_q, state_d;
   logic          load, shift_en;
   logic [W-1:0]  val_a, val_b;
   logic [CW-1:0] cnt_a, cnt_b;
   logic          need_a, need_b, done;
   logic [CW:0]   shamt_q, shamt_d;
   logic          zero_q, zero_d;

   function automatic logic [CW:0] calc_shamt(input logic [CW-1:0] ca,
                                              input logic [CW-1:0] cb);
      logic [CW:0] sum;
      sum = {1'b0, ca} + {1'b0, cb};
      return TOTAL_SH - sum;
   endfunction

   leading_one_shifter #(.W(W), .M(M), .CW(CW)) u_lane_a (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .en   (shift_en),
      .din  (a),
      .val  (val_a),
      .cnt  (cnt_a),
      .need (need_a)
   );

   leading_one_shifter #(.W(W), .M(M), .CW(CW)) u_lane_b (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .en   (shift_en),
      .din  (b),
      .val  (val_b),
      .cnt  (cnt_b),
      .need (need_b)
   );

   assign done = !need_a && !need_b;

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      shift_en  = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_SHIFT: begin
            shift_en = 1'b1;
            if (done) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: begin
            in_ready = 1'b1;
            state_d  = ST_IDLE;
            if (in_valid) begin
               load    = 1'b1;
               state_d = ST_SHIFT;
            end
         end
      endcase
   end

   // Result fields are frozen on the SHIFT->HOLD edge so they stay stable in HOLD.
   always_comb begin
      shamt_d = shamt_q;
      zero_d  = zero_q;
      if (shift_en && done) begin
         shamt_d = calc_shamt(cnt_a, cnt_b);
         zero_d  = (val_a == '0) || (val_b == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shamt_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shamt_q <= shamt_d;
         zero_q  <= zero_d;
      end
   end

   assign shifting_a = shift_en && need_a;
   assign shifting_b = shift_en && need_b;
   assign man_a      = val_a[W-1 -: M];
   assign man_b      = val_b[W-1 -: M];
   assign shamt      = shamt_q;
   assign zero       = zero_q;

endmodule

// File: tb/tb_operand_normalizer.sv
// Bench for operand_normalizer: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_operand_normalizer;

   localparam int W  = 16;
   localparam int M  = 8;
   localparam int CW = 4;
   localparam int MAXS = W - M;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, out_ready;
   logic [W-1:0]  a, b;
   logic          in_ready, shifting_a, shifting_b, out_valid, zero;
   logic [M-1:0]  man_a, man_b;
   logic [CW:0]   shamt;

   int n_chk  = 0;
   int n_pass = 0;
   int results = 0;
   logic mon_en = 1'b0;

   operand_normalizer #(.W(W), .M(M), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .shifting_a (shifting_a),
      .shifting_b (shifting_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .man_a      (man_a),
      .man_b      (man_b),
      .shamt      (shamt),
      .zero       (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference: shift count is the leading-zero count, capped at W-M.
   function automatic int ref_cnt(input logic [W-1:0] x);
      int c = 0;
      for (int i = W - 1; i >= 0; i--) begin
         if (x[i]) break;
         c++;
      end
      return (c > MAXS) ? MAXS : c;
   endfunction

   function automatic logic [M-1:0] ref_man(input logic [W-1:0] x);
      logic [W-1:0] y;
      y = x << ref_cnt(x);
      return y[W-1 -: M];
   endfunction

   function automatic int ref_max(input logic [W-1:0] x, input logic [W-1:0] y);
      return (ref_cnt(x) > ref_cnt(y)) ? ref_cnt(x) : ref_cnt(y);
   endfunction

   // Transaction model: m_e counts edges since the accept edge.
   logic         m_busy = 1'b0;
   int           m_e = 0, m_n = 0, m_ca = 0, m_cb = 0;
   logic [M-1:0] m_mana = '0, m_manb = '0;
   int           m_shamt = 0;
   logic         m_zero = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy  <= 1'b1;
            m_e     <= 0;
            m_ca    <= ref_cnt(a);
            m_cb    <= ref_cnt(b);
            m_n     <= ref_max(a, b);
            m_mana  <= ref_man(a);
            m_manb  <= ref_man(b);
            m_shamt <= 2 * MAXS - ref_cnt(a) - ref_cnt(b);
            m_zero  <= (a == '0) || (b == '0);
         end
      end else if (m_e == m_n + 1) begin
         if (out_ready) begin
            m_busy  <= 1'b0;
            results <= results + 1;
         end
      end else begin
         m_e <= m_e + 1;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_ov;
         exp_ov = m_busy && (m_e == m_n + 1);
         check("in_ready", in_ready, !m_busy);
         check("out_valid", out_valid, exp_ov);
         check("shifting_a", shifting_a, m_busy && (m_e < m_ca));
         check("shifting_b", shifting_b, m_busy && (m_e < m_cb));
         if (exp_ov) begin
            check("man_a", man_a, m_mana);
            check("man_b", man_b, m_manb);
            check("shamt", shamt, m_shamt);
            check("zero", zero, m_zero);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
      a = va;
      b = vb;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int start, output int edges);
      edges = start;
      while (!out_valid && edges < 40) begin
         step();
         edges++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      step();
      step();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_shifting", {shifting_a, shifting_b}, 0);
      check("rst_zero", zero, 0);
      check("rst_man", {man_a, man_b}, 0);
      check("rst_shamt", shamt, 0);
      rst = 1'b0;
      mon_en = 1'b1;

      check("model_cnt_0100", ref_cnt(16'h0100), 7);
      check("model_cnt_0001", ref_cnt(16'h0001), 8);
      check("model_man_1234", ref_man(16'h1234), 8'h91);
      check("model_man_0000", ref_man(16'h0000), 8'h00);

      step();
      send(16'h8001, 16'hC000);
      check("t1_shift_idle", {shifting_a, shifting_b}, 0);
      wait_valid(0, lat);
      check("t1_latency", lat, 1);
      check("t1_man_a", man_a, 8'h80);
      check("t1_man_b", man_b, 8'hC0);
      check("t1_shamt", shamt, 16);
      release_result();

      send(16'h0100, 16'h0001);
      repeat (6) step();
      check("t2_shift_a_e6", shifting_a, 1);
      step();
      check("t2_shift_a_e7", shifting_a, 0);
      check("t2_shift_b_e7", shifting_b, 1);
      wait_valid(7, lat);
      check("t2_latency", lat, 9);
      check("t2_man_a", man_a, 8'h80);
      check("t2_man_b", man_b, 8'h01);
      check("t2_shamt", shamt, 1);
      check("t2_zero", zero, 0);
      release_result();

      send(16'h0000, 16'h1234);
      wait_valid(0, lat);
      check("t3_latency", lat, 9);
      check("t3_man_a", man_a, 8'h00);
      check("t3_man_b", man_b, 8'h91);
      check("t3_zero", zero, 1);
      check("t3_shamt", shamt, 5);
      release_result();

      send(16'h4000, 16'h2000);
      a = 16'hFFFF;
      b = 16'hFFFF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_valid(1, lat);
      check("t4_latency", lat, 3);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         step();
         check("t4_hold_valid", out_valid, 1);
         check("t4_hold_ready", in_ready, 0);
         check("t4_hold_man_a", man_a, 8'h80);
         check("t4_hold_man_b", man_b, 8'h80);
         check("t4_hold_shamt", shamt, 13);
      end
      in_valid = 1'b0;
      release_result();
      check("t4_back_idle", in_ready, 1);

      send(16'h0010, 16'h0010);
      repeat (2) step();
      rst = 1'b1;
      #1;
      check("t5_async_ready", in_ready, 1);
      check("t5_async_valid", out_valid, 0);
      step();
      rst = 1'b0;
      check("t5_next_ready", in_ready, 1);
      check("t5_next_valid", out_valid, 0);
      send(16'hFFFF, 16'hFFFF);
      wait_valid(0, lat);
      check("t5_latency", lat, 1);
      check("t5_man", {man_a, man_b}, 16'hFFFF);
      check("t5_shamt", shamt, 16);
      release_result();

      begin
         int base;
         base = results;
         in_valid = 1'b1;
         out_ready = 1'b1;
         for (int i = 0; i < 1500; i++) begin
            a = W'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            b = W'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            step();
         end
         in_valid = 1'b0;
         out_ready = 1'b0;
         repeat (12) step();
         check("b2b_results", (results - base) > 100, 1);
      end

      for (int i = 0; i < 2000; i++) begin
         a = W'($urandom_range(0, 65535) >> $urandom_range(0, 16));
         b = W'($urandom_range(0, 65535) >> $urandom_range(0, 16));
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) == 0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) step();
      check("final_idle", in_ready, 1);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
